// File: rtl/rotate_coef_fetch.sv
// rotate_coef_fetch
//
// Converts an integer rotation angle in degrees into a signed cos/sin
// coefficient pair. It reads the quarter-wave cosine ROM twice through a
// single registered read port and folds each word by quadrant.
//
// Optional build macro: ROTATE_COEF_CACHE_EN
//   When this macro is defined, the block keeps the last reduced angle. A request that repeats
//   that angle skips both ROM reads and returns the held pair one cycle after
//   acceptance.
//
// Ports
//   clk, rst    : clock and synchronous active-high reset
//   req_valid   : angle request valid
//   req_ready   : request accepted when high (IDLE only, low during rst)
//   req_angle   : angle 0..359; 360..511 is reduced by 360 and flagged
//   rom_addr    : registered ROM address
//   rom_data    : ROM read data, ROM_LAT cycles after the sampling edge
//   coef_valid  : coefficient pair valid, held until coef_ready
//   coef_ready  : consumer accepts pair
//   coef_cos    : signed cos, 65536 = 1.0
//   coef_sin    : signed sin, same format
//   angle_err   : request angle was >= 360
//   busy        : FSM is outside IDLE
module rotate_coef_fetch #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [8:0]        req_angle,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [DATA_W:0]   coef_cos,
  output logic [DATA_W:0]   coef_sin,
  output logic              angle_err,
  output logic              busy
);

  localparam int unsigned CW = DATA_W + 1;

  typedef enum logic [2:0] {StIdle, StRdCos, StRdSin, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [1:0]        quad_q, quad_d;
  logic [6:0]        rem_q, rem_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [CW-1:0]     cos_q, cos_d;
  logic [CW-1:0]     sin_q, sin_d;
  logic              err_q, err_d;

`ifdef ROTATE_COEF_CACHE_EN
  logic [8:0]        cache_angle_q, cache_angle_d;
  logic              cache_vld_q, cache_vld_d;
  logic              hit_q, hit_d;
`endif

  // Angle reduction and quadrant split of the incoming request
  logic [8:0] ang_red;
  logic [1:0] quad_new;
  logic [6:0] rem_new;

  always_comb begin
    ang_red = (req_angle >= 9'd360) ? req_angle - 9'd360 : req_angle;
    if (ang_red >= 9'd270) begin
      quad_new = 2'd3;
      rem_new  = 7'(ang_red - 9'd270);
    end else if (ang_red >= 9'd180) begin
      quad_new = 2'd2;
      rem_new  = 7'(ang_red - 9'd180);
    end else if (ang_red >= 9'd90) begin
      quad_new = 2'd1;
      rem_new  = 7'(ang_red - 9'd90);
    end else begin
      quad_new = 2'd0;
      rem_new  = 7'(ang_red);
    end
  end

  // Odd quadrants read cos from T[90-r]; sin always uses the other index.
  function automatic logic [ADDR_W-1:0] rom_index(input logic [1:0] quad,
                                                   input logic [6:0] rem,
                                                   input logic       want_sin);
    logic [6:0] idx;
    idx = (quad[0] ^ want_sin) ? (7'd90 - rem) : rem;
    return ADDR_W'(idx);
  endfunction

  // Zero-extend then negate; negating zero yields zero in two's complement.
  function automatic logic [CW-1:0] fold(input logic [DATA_W-1:0] word, input logic neg);
    logic [CW-1:0] ext;
    ext = CW'(word);
    return neg ? (~ext + 1'b1) : ext;
  endfunction

  logic cos_neg, sin_neg;
  assign cos_neg = quad_q[0] ^ quad_q[1];  // quadrants 1 and 2
  assign sin_neg = quad_q[1];              // quadrants 2 and 3

  always_comb begin
    state_d    = state_q;
    quad_d     = quad_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    cos_d      = cos_q;
    sin_d      = sin_q;
    err_d      = err_q;
`ifdef ROTATE_COEF_CACHE_EN
    cache_angle_d = cache_angle_q;
    cache_vld_d   = cache_vld_q;
    hit_d         = hit_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          err_d  = (req_angle >= 9'd360);
          quad_d = quad_new;
          rem_d  = rem_new;
`ifdef ROTATE_COEF_CACHE_EN
          if (cache_vld_q && (cache_angle_q == ang_red)) begin
            // Pair registers still hold this angle's result; pass through WAIT
            // without touching the ROM so valid rises one cycle later.
            hit_d   = 1'b1;
            state_d = StWait;
          end else begin
            hit_d         = 1'b0;
            cache_angle_d = ang_red;
            cache_vld_d   = 1'b0;
            rom_addr_d    = rom_index(quad_new, rem_new, 1'b0);
            state_d       = StRdCos;
          end
`else
          rom_addr_d = rom_index(quad_new, rem_new, 1'b0);
          state_d    = StRdCos;
`endif
        end
      end

      StRdCos: begin
        rom_addr_d = rom_index(quad_q, rem_q, 1'b1);
        cnt_d      = 2'(ROM_LAT);
        state_d    = StRdSin;
      end

      // Count down until the cos word is on rom_data; the sin word follows
      // exactly one cycle later and is captured in WAIT.
      StRdSin: begin
        if (cnt_q == 2'd1) begin
          cos_d   = fold(rom_data, cos_neg);
          state_d = StWait;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      StWait: begin
`ifdef ROTATE_COEF_CACHE_EN
        if (!hit_q) begin
          sin_d       = fold(rom_data, sin_neg);
          cache_vld_d = 1'b1;
        end
`else
        sin_d = fold(rom_data, sin_neg);
`endif
        state_d = StHold;
      end

      StHold: begin
        if (coef_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      quad_q     <= 2'd0;
      rem_q      <= 7'd0;
      cnt_q      <= 2'd0;
      rom_addr_q <= '0;
      cos_q      <= '0;
      sin_q      <= '0;
      err_q      <= 1'b0;
`ifdef ROTATE_COEF_CACHE_EN
      cache_angle_q <= 9'd0;
      cache_vld_q   <= 1'b0;
      hit_q         <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      quad_q     <= quad_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      cos_q      <= cos_d;
      sin_q      <= sin_d;
      err_q      <= err_d;
`ifdef ROTATE_COEF_CACHE_EN
      cache_angle_q <= cache_angle_d;
      cache_vld_q   <= cache_vld_d;
      hit_q         <= hit_d;
`endif
    end
  end

  assign req_ready  = (state_q == StIdle) && !rst;
  assign busy       = (state_q != StIdle);
  assign coef_valid = (state_q == StHold);
  assign rom_addr   = rom_addr_q;
  assign coef_cos   = cos_q;
  assign coef_sin   = sin_q;
  assign angle_err  = err_q;

endmodule

// File: tb/tb_rotate_coef_fetch.sv
// Directed testbench for rotate_coef_fetch with a behavioural ROM
// (ROM_LAT = 1) and a scoreboard of expected coefficient pairs.
module tb_rotate_coef_fetch;

  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [8:0]         req_angle;
  logic [7:0]         rom_addr;
  logic [17:0]        rom_data;
  logic               coef_valid;
  logic               coef_ready;
  logic signed [18:0] coef_cos;
  logic signed [18:0] coef_sin;
  logic               angle_err;
  logic               busy;

  always #5 clk = ~clk;

  rotate_coef_fetch #(
    .ADDR_W (8),
    .DATA_W (18),
    .ROM_LAT(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_angle (req_angle),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .coef_valid(coef_valid),
    .coef_ready(coef_ready),
    .coef_cos  (coef_cos),
    .coef_sin  (coef_sin),
    .angle_err (angle_err),
    .busy      (busy)
  );

  logic [17:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    int c;
    int s;
    int e;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic int rnd(input real x);
    return int'($floor(x + 0.5));
  endfunction

  // Reference pair straight from trig of the reduced angle.
  function automatic exp_t model(input int ang);
    exp_t r;
    int   a;
    real  rad;
    a   = (ang >= 360) ? ang - 360 : ang;
    rad = real'(a) * PI / 180.0;
    r.c = rnd($cos(rad) * 65536.0);
    r.s = rnd($sin(rad) * 65536.0);
    r.e = (ang >= 360) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one request; returns one step after the accepting edge.
  task automatic send(input int ang);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_angle = 9'(ang);
    while (!req_ready && n < 50) begin
      tick;
      n++;
    end
    chk("req_ready_wait", (n < 50) ? 1 : 0, 1);
    sb.push_back(model(ang));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_pair(input string tag, input exp_t e);
    chk({tag, "_cos"}, coef_cos, e.c);
    chk({tag, "_sin"}, coef_sin, e.s);
    chk({tag, "_err"}, angle_err, e.e);
  endtask

  // Wait for the pair, check latency and values, complete the handshake.
  task automatic recv(input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (!coef_valid && n < 20) begin
      tick;
      n++;
    end
    chk("latency", n, exp_lat);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_pair("result", e);
    end else begin
      chk("scoreboard_empty", 1, 0);
    end
    tick;
    chk("valid_drop", coef_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    int   a0;
    exp_t e;
    int   angles[10] = '{89, 90, 91, 179, 180, 181, 269, 359, 360, 511};

    for (int k = 0; k < 256; k++) begin
      rom_mem[k] = (k <= 90) ? 18'(rnd($cos(real'(k) * PI / 180.0) * 65536.0)) : 18'd0;
    end

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_angle  = 9'd0;
    coef_ready = 1'b1;
    repeat (3) tick;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_coef_valid", coef_valid, 0);
    chk("rst_cos", coef_cos, 0);
    chk("rst_sin", coef_sin, 0);
    chk("rst_err", angle_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", req_ready, 1);

    send(0);
    recv(3);

    send(150);
    chk("addr_cos_150", rom_addr, 30);
    tick;
    chk("addr_sin_150", rom_addr, 60);
    recv(2);

    send(270);
    recv(3);
    send(400);
    recv(3);

    foreach (angles[i]) begin
      send(angles[i]);
      recv(3);
    end

    // Backpressure: consumer stalls while a new request is offered.
    coef_ready = 1'b0;
    send(200);
    n = 0;
    while (!coef_valid && n < 20) begin
      tick;
      n++;
    end
    chk("bp_latency", n, 3);
    e         = sb.pop_front();
    req_valid = 1'b1;
    req_angle = 9'd10;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_valid", coef_valid, 1);
      chk("bp_ready", req_ready, 0);
      check_pair("bp_hold", e);
    end
    coef_ready = 1'b1;
    tick;
    chk("bp_valid_drop", coef_valid, 0);
    chk("bp_busy_after", busy, 0);
    chk("bp_ready_after", req_ready, 1);
    sb.push_back(model(10));
    tick;
    req_valid = 1'b0;
    chk("bp_accepted", busy, 1);
    recv(3);

    // Reset while in RD_SIN aborts the request.
    send(100);
    void'(sb.pop_back());
    tick;
    rst = 1'b1;
    tick;
    chk("abort_req_ready", req_ready, 0);
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_coef_valid", coef_valid, 0);
    chk("abort_cos", coef_cos, 0);
    chk("abort_sin", coef_sin, 0);
    chk("abort_err", angle_err, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    n   = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (coef_valid) n++;
    end
    chk("abort_no_valid", n, 0);

`ifdef ROTATE_COEF_CACHE_EN
    send(45);
    recv(3);
    a0 = rom_addr;
    send(45);
    chk("cache_addr_hold", rom_addr, a0);
    recv(1);
    send(405);
    chk("cache_addr_hold2", rom_addr, a0);
    recv(1);
`else
    a0 = 0;
    send(45);
    recv(3);
    chk("addr_sin_45", rom_addr, 45);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
